// File: rtl/fsqrt_wb.sv
// ============================================================================
// Module   : fsqrt_wb
// Purpose  : Issue/writeback wrapper around a fixed-latency pipelined sqrt core
//            with special-case substitution and a credit-controlled result FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsqrt_wb #(
    parameter int NSTAGE = 4,
    parameter int TAG_W  = 5,
    parameter int DEPTH  = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_x,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      core_x,
    input  logic [31:0]      core_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_y,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_nv
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = 32 + TAG_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [31:0]      QNAN     = 32'h7FC00000;
    localparam logic [31:0]      PINF     = 32'h7F800000;

    logic             acc;
    logic             pop;
    logic             push;
    logic [CNT_W-1:0] occ;
    logic [ENT_W-1:0] push_data;

    // occ counts everything in flight plus buffered, so the core never overruns the FIFO
    assign in_ready = !rstn && (occ < FULL_CNT);
    assign acc      = in_valid & in_ready;
    assign pop      = out_valid & out_ready;
    assign core_x   = acc ? in_x : 32'h0;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            occ <= '0;
        end else if (acc && !pop) begin
            occ <= occ + 1'b1;
        end else if (!acc && pop) begin
            occ <= occ - 1'b1;
        end
    end

    logic        cls_special;
    logic        cls_nv;
    logic [31:0] cls_val;

    always_comb begin
        cls_special = 1'b1;
        cls_nv      = 1'b0;
        cls_val     = QNAN;
        if (in_x[30:23] == 8'hFF && in_x[22:0] != 23'h0) begin
            cls_val = QNAN;
        end else if (in_x[30:23] == 8'h00) begin
            cls_val = {in_x[31], 31'h0};
        end else if (in_x[31]) begin
            cls_nv = 1'b1;
        end else if (in_x[30:23] == 8'hFF) begin
            cls_val = PINF;
        end else begin
            cls_special = 1'b0;
            cls_val     = 32'h0;
        end
    end

    logic             sh_valid   [NSTAGE];
    logic [TAG_W-1:0] sh_tag     [NSTAGE];
    logic             sh_special [NSTAGE];
    logic [31:0]      sh_val     [NSTAGE];
    logic             sh_nv      [NSTAGE];

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            for (int i = 0; i < NSTAGE; i++) begin
                sh_valid[i]   <= 1'b0;
                sh_tag[i]     <= '0;
                sh_special[i] <= 1'b0;
                sh_val[i]     <= '0;
                sh_nv[i]      <= 1'b0;
            end
        end else begin
            sh_valid[0]   <= acc;
            sh_tag[0]     <= in_tag;
            sh_special[0] <= cls_special;
            sh_val[0]     <= cls_val;
            sh_nv[0]      <= cls_nv;
            for (int i = 1; i < NSTAGE; i++) begin
                sh_valid[i]   <= sh_valid[i-1];
                sh_tag[i]     <= sh_tag[i-1];
                sh_special[i] <= sh_special[i-1];
                sh_val[i]     <= sh_val[i-1];
                sh_nv[i]      <= sh_nv[i-1];
            end
        end
    end

    assign push      = sh_valid[NSTAGE-1];
    assign push_data = {sh_special[NSTAGE-1] ? sh_val[NSTAGE-1] : core_y,
                        sh_tag[NSTAGE-1], sh_nv[NSTAGE-1]};

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_next;
    logic [PTR_W-1:0] wr_next;
    logic [CNT_W-1:0] count;

    assign rd_next   = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
    assign wr_next   = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
    assign out_valid = (count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Output registers mirror the head entry; they are refreshed whenever the head changes
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            out_y   <= '0;
            out_tag <= '0;
            out_nv  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_next;
            end
            if (pop) begin
                rd_ptr <= rd_next;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
            if (pop) begin
                if (count > ONE_CNT) begin
                    {out_y, out_tag, out_nv} <= mem[rd_next];
                end else if (push) begin
                    {out_y, out_tag, out_nv} <= push_data;
                end
            end else if (count == '0 && push) begin
                {out_y, out_tag, out_nv} <= push_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fsqrt_wb.sv
// ============================================================================
// Module   : tb_fsqrt_wb
// Purpose  : Directed self-checking bench for fsqrt_wb with a behavioural core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fsqrt_wb;

    localparam int NSTAGE = 4;
    localparam int TAG_W  = 5;
    localparam int DEPTH  = 8;
    localparam int ENT_W  = 32 + TAG_W + 1;
    localparam logic [31:0] X4 = 32'h40800000;

    logic             clk = 1'b0;
    logic             rstn = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_x = 32'h0;
    logic [TAG_W-1:0] in_tag = '0;
    logic [31:0]      core_x;
    logic [31:0]      core_y;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_y;
    logic [TAG_W-1:0] out_tag;
    logic             out_nv;

    int checks = 0;
    int failures = 0;
    int n_acc = 0;
    int n_pop = 0;
    logic [ENT_W-1:0] exp_q [$];

    always #5 clk = ~clk;

    fsqrt_wb #(.NSTAGE(NSTAGE), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_tag(in_tag), .core_x(core_x), .core_y(core_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .out_tag(out_tag), .out_nv(out_nv)
    );

    // Behavioural core: correct for normal positives, garbage for everything else
    function automatic logic [31:0] core_fn(input logic [31:0] x);
        logic [63:0] d;
        logic [63:0] b;
        logic [30:0] mag;
        real r;
        if (x[31] || x[30:23] == 8'h00 || x[30:23] == 8'hFF) return 32'hDEADBEEF;
        d = {1'b0, 11'({3'b000, x[30:23]} + 11'd896), x[22:0], 29'b0};
        r = $sqrt($bitstoreal(d));
        b = $realtobits(r);
        mag = {8'(b[62:52] - 11'd896), b[51:29]} + {30'b0, b[28]};
        return {1'b0, mag};
    endfunction

    logic [31:0] core_pipe [NSTAGE];
    always @(posedge clk) begin
        core_pipe[0] <= core_fn(core_x);
        for (int i = 1; i < NSTAGE; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign core_y = core_pipe[NSTAGE-1];

    function automatic logic [ENT_W-1:0] ref_out(input logic [31:0] x, input logic [TAG_W-1:0] t);
        logic [31:0] y;
        logic nv;
        nv = 1'b0;
        if (x[30:23] == 8'hFF && x[22:0] != 23'h0) y = 32'h7FC00000;
        else if (x[30:23] == 8'h00) y = {x[31], 31'h0};
        else if (x[31]) begin y = 32'h7FC00000; nv = 1'b1; end
        else if (x[30:23] == 8'hFF) y = 32'h7F800000;
        else y = core_fn(x);
        return {y, t, nv};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // One clock: drive at the falling edge, then record what the next rising edge will do
    task automatic step(input logic v, input logic r, input logic [31:0] x,
                        input logic [TAG_W-1:0] t, output logic accepted, output logic popped);
        logic [ENT_W-1:0] e;
        @(negedge clk);
        in_valid  = v;
        in_x      = x;
        in_tag    = t;
        out_ready = r;
        popped    = out_valid && r;
        accepted  = v && in_ready;
        if (popped) begin
            n_pop++;
            if (exp_q.size() == 0) check("unexpected_pop", 64'(out_valid), 64'd0);
            else begin
                e = exp_q.pop_front();
                check("pop_entry", 64'({out_y, out_tag, out_nv}), 64'(e));
            end
        end
        if (accepted) begin
            n_acc++;
            exp_q.push_back(ref_out(x, t));
        end
    endtask

    task automatic drain();
        logic a, p;
        int k;
        k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < 200) begin
            step(1'b0, 1'b1, 32'h0, '0, a, p);
            k++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        check("acc_eq_pop", 64'(n_pop), 64'(n_acc));
    endtask

    task automatic single_op(input logic [31:0] x, input logic [TAG_W-1:0] t,
                             input logic [31:0] y_exp, input logic nv_exp);
        int lat;
        @(negedge clk);
        check("single_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_x = x; in_tag = t; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("single_latency", 64'(lat), 64'(NSTAGE));
        check("single_out", 64'({out_y, out_tag, out_nv}), 64'({y_exp, t, nv_exp}));
        @(negedge clk);
        check("single_drained", 64'(out_valid), 64'd0);
    endtask

    logic [31:0] sp_x [4] = '{32'hBF800000, 32'h80000000, 32'h7F800000, 32'h7FC00001};

    initial begin
        logic a, p;
        int cnt, cyc;
        logic [31:0] cur_x;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out", 64'({out_valid, out_y, out_tag, out_nv}), 64'd0);
        rstn = 1'b0;
        #1;
        check("rel_in_ready", 64'(in_ready), 64'd1);

        // Single op: sqrt(4.0) = 2.0
        single_op(X4, 5'd3, 32'h40000000, 1'b0);

        // Specials back to back; core returns garbage for them
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, sp_x[i], TAG_W'(10 + i), a, p);
            check("spec_accept", 64'(a), 64'd1);
        end
        step(1'b0, 1'b1, 32'h0, '0, a, p);
        check("spec_gap", 64'(p), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 32'h0, '0, a, p);
            check("spec_consec", 64'(p), 64'd1);
        end
        drain();

        // Backpressure: fill to DEPTH with out_ready low
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, X4 + 32'(cnt), TAG_W'(cnt), a, p);
            if (a) cnt++;
        end
        check("bp_accepts", 64'(cnt), 64'(DEPTH));
        check("bp_ready_low", 64'(in_ready), 64'd0);

        // Full with simultaneous pop and in_valid: no accept this cycle, accept next
        step(1'b1, 1'b1, X4 + 32'(cnt), TAG_W'(cnt), a, p);
        check("full_no_accept", 64'(a), 64'd0);
        check("full_pop", 64'(p), 64'd1);
        step(1'b1, 1'b1, X4 + 32'(cnt), TAG_W'(cnt), a, p);
        check("full_ready_next", 64'(a), 64'd1);
        if (a) cnt++;
        cyc = 0;
        while (cnt < 10 && cyc < 100) begin
            step(1'b1, 1'b1, X4 + 32'(cnt), TAG_W'(cnt), a, p);
            if (a) cnt++;
            cyc++;
        end
        check("bp_total", 64'(cnt), 64'd10);
        drain();

        // Streaming random normal positives with random out_ready
        cnt = 0; cyc = 0;
        cur_x = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
        while (cnt < 1000 && cyc < 20000) begin
            step(1'b1, 1'($urandom_range(0, 1)), cur_x, TAG_W'(cnt), a, p);
            if (a) begin
                cnt++;
                cur_x = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
            end
            cyc++;
        end
        check("stream_count", 64'(cnt), 64'd1000);
        drain();

        // Reset mid-flight: three ops accepted, then reset discards them
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, X4, TAG_W'(20 + i), a, p);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        n_acc = 0; n_pop = 0;
        @(negedge clk);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check("midrst_rel_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < NSTAGE + 4; i++) step(1'b0, 1'b1, 32'h0, '0, a, p);
        check("midrst_no_output", 64'(n_pop), 64'd0);
        single_op(32'h41100000, 5'd7, 32'h40400000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fsqrt_wb.md
Name: fsqrt_wb

Overview:
- Issue/writeback wrapper around the fixed-latency pipelined `sqrt` core (ports x1, y, clk, rstn; NSTAGE register stages; no stall input).
- Accepts operands with a valid/ready handshake and drives the core input.
- Carries the destination tag and special-case class alongside the core in a shadow pipeline, then substitutes IEEE special results.
- Buffers finished results in an in-order FIFO toward register-file writeback.
- Provides backpressure by occupancy credit, because the core cannot stall.

Parameters:
- NSTAGE, 4: core latency in clock edges from x1 sample to matching y.
- TAG_W, 5: destination tag width.
- DEPTH, 8: output FIFO depth and maximum ops in flight plus buffered. Must be at least 2.

Ports:
- clk  in  1  single clock, rising edge.
- rstn  in  1  reset, asynchronous, active-high (asserted = 1 despite the name).
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept.
- in_x  in  32  IEEE-754 single operand.
- in_tag  in  TAG_W  destination tag.
- core_x  out  32  to sqrt x1.
- core_y  in  32  from sqrt y.
- out_valid  out  1  result available.
- out_ready  in  1  writeback consumes.
- out_y  out  32  result.
- out_tag  out  TAG_W  tag of out_y.
- out_nv  out  1  invalid-operation flag.

Behaviour:
- Accept: acc = in_valid & in_ready, sampled at the rising edge.
- Output pop: pop = out_valid & out_ready.
- Credit counter occ, width clog2(DEPTH)+1:
  - +1 on acc, −1 on pop; unchanged if both occur in the same cycle.
  - in_ready = !rstn_asserted & (occ < DEPTH), decoded from registers only.
  - Never combinationally dependent on out_ready. At occ = DEPTH, a same-cycle pop does not enable accept.
- Core input: core_x = acc ? in_x : 32'h0, combinational. Non-accepted cycles feed zero so core contents are don't-care.
- Classification of in_x, computed at accept and stored in the shadow pipeline. Let e = in_x[30:23], m = in_x[22:0], s = in_x[31].
  - e = 255 and m ≠ 0: NaN → 32'h7FC00000, nv = 0.
  - e = 0 (zero or subnormal, flushed): {s, 31'h0}, nv = 0.
  - s = 1, otherwise: 32'h7FC00000, nv = 1.
  - e = 255, s = 0: 32'h7F800000, nv = 0.
  - else: normal; result = core_y, nv = 0.
  - Priority is top to bottom.
- Shadow pipeline:
  - NSTAGE stages of {valid, tag, special, sp_val, nv}.
  - Stage 1 is loaded with acc at the accept edge; stages shift every edge unconditionally.
  - Stage NSTAGE is aligned with core_y.
- FIFO push:
  - Push occurs at the edge where shadow stage NSTAGE is valid; the entry is {special ? sp_val : core_y, tag, nv}.
  - Push can never overflow because occ counts in-flight ops.
- FIFO:
  - DEPTH entries, circular read/write pointers that wrap at DEPTH, strictly in order.
  - Outputs are registered from the head entry; out_valid = count ≠ 0.
  - Simultaneous push and pop is legal at any count, including full and one-entry.
  - Head is stable while out_valid & !out_ready.
- Latency: take the accept edge as edge 0. With the FIFO empty, the result is pushed at edge NSTAGE and out_valid = 1 after edge NSTAGE, i.e. in cycle NSTAGE+1. Throughput is one op per clock while out_ready = 1.
- Reset (async, any time):
  - occ = 0; all shadow valids = 0; FIFO pointers and count = 0.
  - out_valid = 0, out_y = 0, out_tag = 0, out_nv = 0, in_ready = 0 while asserted.
  - In-flight ops are discarded. Core outputs arriving after reset are ignored because shadow valids are cleared.
  - in_ready = 1 in the first cycle after deassertion.

Test Plan:
- Single op, out_ready = 1: in_x = 32'h40800000 (4.0), tag 3 → out_valid in cycle NSTAGE+1 = 5, out_y = 32'h40000000, out_tag 3, nv 0.
- Specials back-to-back in 4 consecutive cycles, core returning garbage: 32'hBF800000 → 7FC00000 nv 1; 32'h80000000 → 80000000 nv 0; 32'h7F800000 → 7F800000; 32'h7FC00001 → 7FC00000 nv 0. Outputs appear in order on 4 consecutive cycles.
- Backpressure: out_ready = 0, continuous in_valid with tags 0..9 → exactly 8 accepts and in_ready = 0 from then on. Raise out_ready → tags 0..7 emerge in order, then accepts resume with tags 8, 9.
- Full with simultaneous events: occ = 8, pop and in_valid in the same cycle → no accept that cycle, occ = 7, in_ready = 1 next cycle.
- Streaming 1000 random normal positives, out_ready toggling randomly → results ±1 ulp of the $sqrt reference, tags in order, no loss or duplication.
- Reset mid-flight: accept 3 ops, assert rstn (=1) at edge 2 for 1 cycle → out_valid never rises for those ops. A new op after release returns correctly at latency NSTAGE+1.
